// File: rtl/fanout_fork_pkg.sv
// Shared constants and mask type for the fanout fork.
// Package name fanout_pkg is kept for compatibility with existing importers.
package fanout_pkg;

    localparam int unsigned FANOUT_MAX_OUT = 32;
    localparam int unsigned STALL_CNT_W    = 16;

    typedef logic [FANOUT_MAX_OUT-1:0] fanout_mask_t;

    function automatic fanout_mask_t fanout_onehot(input int unsigned idx);
        fanout_onehot      = '0;
        fanout_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/fanout_fork_if.sv
// Upstream/downstream ready-valid bundle for fanout_fork.
// The fork itself connects through the slave modport; the environment uses master.
interface fanout_fork_if #(
    parameter int unsigned NUM_OUT = 9,
    parameter int unsigned DATA_W  = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
    logic [DATA_W-1:0]  out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fanout_fork_ready_and.sv
// NUM_OUT-wide ready reduction: a branch is satisfied when inactive, already
// done, ready, or explicitly ignored (used to exclude a branch from its own term).
module fanout_ready_and #(
    parameter int unsigned NUM_OUT = 9
) (
    input  logic [NUM_OUT-1:0] act,
    input  logic [NUM_OUT-1:0] done,
    input  logic [NUM_OUT-1:0] ready,
    input  logic [NUM_OUT-1:0] ignore,
    output logic               all_ready
);
    always_comb begin
        all_ready = 1'b1;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            all_ready = all_ready & (~act[i] | done[i] | ready[i] | ignore[i]);
        end
    end
endmodule

// File: rtl/fanout_fork.sv
// Ready/valid fork broadcasting one token to all active branches (EAGER or lazy).
// Optional FANOUT_FORK_STALL_CNT_EN adds stall_cnt and stall_branch outputs.
module fanout_fork
    import fanout_pkg::*;
#(
    parameter int unsigned NUM_OUT = 9,
    parameter int unsigned DATA_W  = 32,
    parameter bit          EAGER   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_OUT-1:0] cfg_en,
    input  logic [NUM_OUT-1:0] cfg_sel,
    fanout_fork_if.slave       bus
`ifdef FANOUT_FORK_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [NUM_OUT-1:0]     stall_branch
`endif
);
    logic [NUM_OUT-1:0] act;
    logic [NUM_OUT-1:0] done;
    logic               fire;

    assign act          = cfg_en & cfg_sel;
    assign bus.out_data = bus.in_data[DATA_W-1:0];
    assign fire         = bus.in_valid & bus.in_ready;

    fanout_ready_and #(.NUM_OUT(NUM_OUT)) u_in_ready (
        .act       (act),
        .done      (done),
        .ready     (bus.out_ready),
        .ignore    ('0),
        .all_ready (bus.in_ready)
    );

    if (EAGER) begin : g_eager
        // Masking with act keeps deactivated branches from holding stale done bits.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                done <= '0;
            end else if (fire) begin
                done <= '0;
            end else begin
                done <= (done | (bus.out_valid & bus.out_ready)) & act;
            end
        end

        assign bus.out_valid = {NUM_OUT{bus.in_valid}} & act & ~done;
    end else begin : g_lazy
        assign done = '0;

        // Each branch is offered only when every other active branch is ready too.
        for (genvar i = 0; i < NUM_OUT; i++) begin : g_branch
            localparam fanout_mask_t SELF = fanout_onehot(i);
            logic others_ready;

            fanout_ready_and #(.NUM_OUT(NUM_OUT)) u_others (
                .act       (act),
                .done      (done),
                .ready     (bus.out_ready),
                .ignore    (SELF[NUM_OUT-1:0]),
                .all_ready (others_ready)
            );

            assign bus.out_valid[i] = bus.in_valid & act[i] & others_ready;
        end
    end

`ifdef FANOUT_FORK_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (bus.in_valid && !bus.in_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign stall_branch = act & ~done & ~bus.out_ready & {NUM_OUT{bus.in_valid}};
`endif

endmodule

// File: tb/tb_fanout_fork.sv
// Directed bench for fanout_fork: an EAGER and a lazy instance share stimulus.
module tb_fanout_fork;
    import fanout_pkg::*;

    localparam int unsigned N = 3;
    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] cfg_en;
    logic [N-1:0] cfg_sel;
    int           tests_run;
    int           tests_failed;

    fanout_fork_if #(.NUM_OUT(N), .DATA_W(W)) bus_e ();
    fanout_fork_if #(.NUM_OUT(N), .DATA_W(W)) bus_l ();

`ifdef FANOUT_FORK_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_e, stall_cnt_l;
    logic [N-1:0]           stall_branch_e, stall_branch_l;
`endif

    fanout_fork #(.NUM_OUT(N), .DATA_W(W), .EAGER(1'b1)) dut_eager (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_en  (cfg_en),
        .cfg_sel (cfg_sel),
        .bus     (bus_e.slave)
`ifdef FANOUT_FORK_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt_e),
        .stall_branch (stall_branch_e)
`endif
    );

    fanout_fork #(.NUM_OUT(N), .DATA_W(W), .EAGER(1'b0)) dut_lazy (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_en  (cfg_en),
        .cfg_sel (cfg_sel),
        .bus     (bus_l.slave)
`ifdef FANOUT_FORK_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt_l),
        .stall_branch (stall_branch_l)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [N-1:0] r);
        bus_e.in_valid  = v;
        bus_e.in_data   = d;
        bus_e.out_ready = r;
        bus_l.in_valid  = v;
        bus_l.in_data   = d;
        bus_l.out_ready = r;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        cfg_en  = 3'b111;
        cfg_sel = 3'b111;
        drive(1'b0, 32'h0, 3'b000);
        #1;
        tests_run++;
        if (bus_e.out_valid !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %b expected 000", bus_e.out_valid);
        end
        tests_run++;
        if (bus_e.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready_blocked: got %b expected 0", bus_e.in_ready);
        end
        drive(1'b1, 32'h0000_0055, 3'b111);
        #1;
        tests_run++;
        if (bus_e.out_valid !== 3'b111 || bus_e.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_comb: got valid=%b ready=%b expected 111/1", bus_e.out_valid, bus_e.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_all_ready();
        apply_reset();
        drive(1'b1, 32'hA5A5_0001, 3'b111);
        #1;
        tests_run++;
        if (bus_e.in_ready !== 1'b1 || bus_e.out_valid !== 3'b111 || bus_e.out_data !== 32'hA5A5_0001) begin
            tests_failed++;
            $display("FAIL all_ready_eager: got ready=%b valid=%b data=%h expected 1/111/a5a50001",
                     bus_e.in_ready, bus_e.out_valid, bus_e.out_data);
        end
        tests_run++;
        if (bus_l.in_ready !== 1'b1 || bus_l.out_valid !== 3'b111) begin
            tests_failed++;
            $display("FAIL all_ready_lazy: got ready=%b valid=%b expected 1/111", bus_l.in_ready, bus_l.out_valid);
        end
        // done must stay clear after a full fire: a new token is offered to everyone
        @(negedge clk);
        drive(1'b1, 32'hA5A5_0002, 3'b000);
        #1;
        tests_run++;
        if (bus_e.out_valid !== 3'b111 || bus_e.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL all_ready_next: got valid=%b ready=%b expected 111/0", bus_e.out_valid, bus_e.in_ready);
        end
    endtask

    task automatic test_staggered();
        apply_reset();
        drive(1'b1, 32'hCAFE_0001, 3'b001);
        #1;
        tests_run++;
        if (bus_e.out_valid !== 3'b111 || bus_e.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stagger_c1_eager: got valid=%b ready=%b expected 111/0", bus_e.out_valid, bus_e.in_ready);
        end
        tests_run++;
        if (bus_l.out_valid !== 3'b000 || bus_l.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stagger_c1_lazy: got valid=%b ready=%b expected 000/0", bus_l.out_valid, bus_l.in_ready);
        end
        @(negedge clk);
        drive(1'b1, 32'hCAFE_0001, 3'b011);
        #1;
        tests_run++;
        if (bus_e.out_valid !== 3'b110 || bus_e.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stagger_c2_eager: got valid=%b ready=%b expected 110/0", bus_e.out_valid, bus_e.in_ready);
        end
        tests_run++;
        if (bus_l.out_valid !== 3'b100) begin
            tests_failed++;
            $display("FAIL stagger_c2_lazy: got valid=%b expected 100", bus_l.out_valid);
        end
        @(negedge clk);
        drive(1'b0, 32'hCAFE_0001, 3'b000);
        #1;
        tests_run++;
        if (bus_e.out_valid !== 3'b000) begin
            tests_failed++;
            $display("FAIL stagger_idle: got valid=%b expected 000", bus_e.out_valid);
        end
        @(negedge clk);
        drive(1'b1, 32'hCAFE_0001, 3'b000);
        #1;
        tests_run++;
        if (bus_e.out_valid !== 3'b100 || bus_e.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stagger_done_held: got valid=%b ready=%b expected 100/0", bus_e.out_valid, bus_e.in_ready);
        end
        @(negedge clk);
        drive(1'b1, 32'hCAFE_0001, 3'b100);
        #1;
        tests_run++;
        if (bus_e.out_valid !== 3'b100 || bus_e.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stagger_c3_eager: got valid=%b ready=%b expected 100/1", bus_e.out_valid, bus_e.in_ready);
        end
        @(negedge clk);
        drive(1'b1, 32'hCAFE_0002, 3'b000);
        #1;
        tests_run++;
        if (bus_e.out_valid !== 3'b111 || bus_e.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stagger_after_fire: got valid=%b ready=%b expected 111/0", bus_e.out_valid, bus_e.in_ready);
        end
    endtask

    task automatic test_sink();
        apply_reset();
        cfg_en  = 3'b000;
        cfg_sel = 3'b111;
        drive(1'b1, 32'hDEAD_BEEF, 3'b000);
        #1;
        tests_run++;
        if (bus_e.in_ready !== 1'b1 || bus_e.out_valid !== 3'b000) begin
            tests_failed++;
            $display("FAIL sink_eager: got ready=%b valid=%b expected 1/000", bus_e.in_ready, bus_e.out_valid);
        end
        tests_run++;
        if (bus_l.in_ready !== 1'b1 || bus_l.out_valid !== 3'b000) begin
            tests_failed++;
            $display("FAIL sink_lazy: got ready=%b valid=%b expected 1/000", bus_l.in_ready, bus_l.out_valid);
        end
        cfg_en = 3'b111;
    endtask

    task automatic test_partial();
        apply_reset();
        cfg_en  = 3'b111;
        cfg_sel = 3'b101;
        drive(1'b1, 32'h0BAD_F00D, 3'b101);
        #1;
        tests_run++;
        if (bus_e.in_ready !== 1'b1 || bus_e.out_valid !== 3'b101) begin
            tests_failed++;
            $display("FAIL partial_eager: got ready=%b valid=%b expected 1/101", bus_e.in_ready, bus_e.out_valid);
        end
        tests_run++;
        if (bus_l.in_ready !== 1'b1 || bus_l.out_valid !== 3'b101) begin
            tests_failed++;
            $display("FAIL partial_lazy: got ready=%b valid=%b expected 1/101", bus_l.in_ready, bus_l.out_valid);
        end
        @(negedge clk);
        drive(1'b1, 32'h0BAD_F00E, 3'b001);
        #1;
        tests_run++;
        if (bus_e.in_ready !== 1'b0 || bus_e.out_valid !== 3'b101) begin
            tests_failed++;
            $display("FAIL partial_eager_stall: got ready=%b valid=%b expected 0/101", bus_e.in_ready, bus_e.out_valid);
        end
        tests_run++;
        if (bus_l.out_valid !== 3'b100) begin
            tests_failed++;
            $display("FAIL partial_lazy_stall: got valid=%b expected 100", bus_l.out_valid);
        end
        cfg_sel = 3'b111;
    endtask

    task automatic test_reset_mid_token();
        apply_reset();
        drive(1'b1, 32'h1234_5678, 3'b001);
        @(negedge clk);
        drive(1'b1, 32'h1234_5678, 3'b010);
        @(negedge clk);
        drive(1'b1, 32'h1234_5678, 3'b000);
        #1;
        tests_run++;
        if (bus_e.out_valid !== 3'b100) begin
            tests_failed++;
            $display("FAIL rst_mid_pending: got valid=%b expected 100", bus_e.out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus_e.out_valid !== 3'b111) begin
            tests_failed++;
            $display("FAIL rst_mid_async_clear: got valid=%b expected 111", bus_e.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus_e.out_valid !== 3'b111 || bus_e.out_data !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL rst_mid_reoffer: got valid=%b data=%h expected 111/12345678", bus_e.out_valid, bus_e.out_data);
        end
    endtask

`ifdef FANOUT_FORK_STALL_CNT_EN
    task automatic test_stall_cnt();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 32'h5555_AAAA, 3'b010);
        #1;
        tests_run++;
        if (stall_cnt_e !== 16'h0000 || stall_branch_e !== 3'b101) begin
            tests_failed++;
            $display("FAIL stall_reset: got cnt=%h branch=%b expected 0000/101", stall_cnt_e, stall_branch_e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (stall_cnt_e !== 16'd5) begin
            tests_failed++;
            $display("FAIL stall_count5: got %0d expected 5", stall_cnt_e);
        end
        repeat (70000) @(posedge clk);
        #1;
        tests_run++;
        if (stall_cnt_e !== 16'hFFFF || stall_cnt_l !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL stall_saturate: got eager=%h lazy=%h expected ffff", stall_cnt_e, stall_cnt_l);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_all_ready();
        test_staggered();
        test_sink();
        test_partial();
        test_reset_mid_token();
`ifdef FANOUT_FORK_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
